// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the multi-cycle MIPS control FSM and its datapath.
// master = control FSM, slave = datapath side.
interface mips_multicycle_control_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic [3:0] state;
  logic       illegal_op;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_en, pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
           ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
           alu_src_b, alu_op, pc_source, state, illegal_op
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_en, pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
           ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
           alu_src_b, alu_op, pc_source, state, illegal_op
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multi-cycle MIPS datapath: sequences fetch, decode,
// execute, memory and write-back, and forms the PC write enable.
module mips_multicycle_control (
  input logic                        clk,
  input logic                        reset,
  mips_multicycle_control_if.master  bus
);

  localparam int unsigned OP_W = 6;
  localparam int unsigned ST_W = 4;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

  typedef enum logic [ST_W-1:0] {
    FETCH      = 4'd0,
    DECODE     = 4'd1,
    MEM_ADDR   = 4'd2,
    MEM_READ   = 4'd3,
    MEM_WB     = 4'd4,
    MEM_WRITE  = 4'd5,
    EXECUTE    = 4'd6,
    R_COMPLETE = 4'd7,
    BRANCH     = 4'd8,
    JUMP       = 4'd9,
    ADDI_EXEC  = 4'd10,
    ADDI_WB    = 4'd11
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [OP_W-1:0] op_q;

  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       illegal_op;

  // State register; opcode is held from DECODE so MEM_ADDR can pick lw vs sw.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) op_q <= bus.opcode;
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    illegal_op    = 1'b0;

    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = bus.mem_ready;
        pc_write  = bus.mem_ready;
        state_d   = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: state_d = MEM_ADDR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDI_EXEC;
          default: begin
            state_d    = FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (op_q == OP_LW) ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        state_d  = bus.mem_ready ? MEM_WB : MEM_READ;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = FETCH;
      end
      MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        state_d   = bus.mem_ready ? FETCH : MEM_WRITE;
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = R_COMPLETE;
      end
      R_COMPLETE: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        state_d       = FETCH;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        state_d   = FETCH;
      end
      ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = ADDI_WB;
      end
      ADDI_WB: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      default: state_d = FETCH;
    endcase

    // Reset silences every control so a mid-instruction reset writes nothing.
    if (reset) begin
      {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
       mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
       pc_source, illegal_op} = '0;
    end
  end

  assign bus.pc_en         = pc_write | (pc_write_cond & bus.zero);
  assign bus.pc_write      = pc_write;
  assign bus.pc_write_cond = pc_write_cond;
  assign bus.i_or_d        = i_or_d;
  assign bus.mem_read      = mem_read;
  assign bus.mem_write     = mem_write;
  assign bus.ir_write      = ir_write;
  assign bus.mem_to_reg    = mem_to_reg;
  assign bus.reg_dst       = reg_dst;
  assign bus.reg_write     = reg_write;
  assign bus.alu_src_a     = alu_src_a;
  assign bus.alu_src_b     = alu_src_b;
  assign bus.alu_op        = alu_op;
  assign bus.pc_source     = pc_source;
  assign bus.illegal_op    = illegal_op;
  assign bus.state         = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: stimulus queues per-cycle
// expectations, a negedge monitor pops and compares them.
module tb_mips_multicycle_control;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BAD   = 6'b111111;

  typedef struct packed {
    logic       pc_en;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

  typedef struct {
    int         cyc;
    logic [3:0] st;
    ctrl_t      c;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  mips_multicycle_control_if ifc();

  mips_multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Control outputs each state is documented to drive; everything else is 0.
  function automatic ctrl_t exp_ctrl(input logic [3:0] st, input logic mr,
                                     input logic z, input logic ill);
    ctrl_t c;
    c = '0;
    case (st)
      4'd0:  begin c.mem_read = 1'b1; c.alu_src_b = 2'b01;
                   c.ir_write = mr; c.pc_write = mr; end
      4'd1:  begin c.alu_src_b = 2'b11; c.illegal_op = ill; end
      4'd2:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      4'd3:  begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
      4'd4:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      4'd5:  begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
      4'd6:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      4'd7:  begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
      4'd8:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b01;
                   c.pc_write_cond = 1'b1; c.pc_source = 2'b01; end
      4'd9:  begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
      4'd10: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      4'd11: begin c.reg_write = 1'b1; end
      default: c = '0;
    endcase
    c.pc_en = c.pc_write | (c.pc_write_cond & z);
    return c;
  endfunction

  // Drive one cycle of inputs and queue what that cycle must look like.
  task automatic step(input logic rst, input logic [5:0] op, input logic mr,
                      input logic z, input logic [3:0] st, input logic ill);
    exp_t e;
    @(posedge clk);
    #1;
    reset         = rst;
    ifc.opcode    = op;
    ifc.mem_ready = mr;
    ifc.zero      = z;
    e.cyc = cyc;
    e.st  = rst ? 4'd0 : st;
    e.c   = rst ? ctrl_t'('0) : exp_ctrl(st, mr, z, ill);
    sb.push_back(e);
  endtask

  function automatic ctrl_t sample_ctrl();
    ctrl_t c;
    c.pc_en         = ifc.pc_en;
    c.pc_write      = ifc.pc_write;
    c.pc_write_cond = ifc.pc_write_cond;
    c.i_or_d        = ifc.i_or_d;
    c.mem_read      = ifc.mem_read;
    c.mem_write     = ifc.mem_write;
    c.ir_write      = ifc.ir_write;
    c.mem_to_reg    = ifc.mem_to_reg;
    c.reg_dst       = ifc.reg_dst;
    c.reg_write     = ifc.reg_write;
    c.alu_src_a     = ifc.alu_src_a;
    c.alu_src_b     = ifc.alu_src_b;
    c.alu_op        = ifc.alu_op;
    c.pc_source     = ifc.pc_source;
    c.illegal_op    = ifc.illegal_op;
    return c;
  endfunction

  // Monitor: compare every queued expectation in the cycle it belongs to.
  initial begin
    exp_t  e;
    ctrl_t a;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        a = sample_ctrl();
        checks++;
        if (e.cyc != cyc) begin
          errors++;
          $display("FAIL stale_entry: queued for cycle %0d, seen at cycle %0d", e.cyc, cyc);
        end else if (ifc.state !== e.st) begin
          errors++;
          $display("FAIL state cyc=%0d: got %0d expected %0d", cyc, ifc.state, e.st);
        end
        checks++;
        if (a !== e.c) begin
          errors++;
          $display("FAIL ctrl cyc=%0d state=%0d: got %h expected %h", cyc, e.st, a, e.c);
        end
      end
    end
  end

  initial begin
    ifc.opcode    = OP_RTYPE;
    ifc.mem_ready = 1'b1;
    ifc.zero      = 1'b0;

    // Reset, then FETCH stall followed by lw with two MEM_READ waits.
    step(1, OP_LW, 1, 0, 0, 0);
    step(1, OP_LW, 1, 0, 0, 0);
    step(0, OP_LW, 0, 0, 0, 0);
    step(0, OP_LW, 0, 0, 0, 0);
    step(0, OP_LW, 1, 0, 0, 0);
    step(0, OP_LW, 1, 0, 1, 0);
    step(0, OP_LW, 1, 0, 2, 0);
    step(0, OP_LW, 0, 0, 3, 0);
    step(0, OP_LW, 0, 0, 3, 0);
    step(0, OP_LW, 1, 0, 3, 0);
    step(0, OP_LW, 1, 1, 4, 0);

    // sw, then R-type with zero high (no effect outside BRANCH).
    step(0, OP_SW, 1, 0, 0, 0);
    step(0, OP_SW, 1, 0, 1, 0);
    step(0, OP_SW, 1, 0, 2, 0);
    step(0, OP_SW, 1, 0, 5, 0);
    step(0, OP_RTYPE, 1, 1, 0, 0);
    step(0, OP_RTYPE, 1, 1, 1, 0);
    step(0, OP_RTYPE, 1, 1, 6, 0);
    step(0, OP_RTYPE, 1, 1, 7, 0);

    // beq taken and not taken.
    step(0, OP_BEQ, 1, 1, 0, 0);
    step(0, OP_BEQ, 1, 1, 1, 0);
    step(0, OP_BEQ, 1, 1, 8, 0);
    step(0, OP_BEQ, 1, 0, 0, 0);
    step(0, OP_BEQ, 1, 0, 1, 0);
    step(0, OP_BEQ, 1, 0, 8, 0);

    // j, addi, illegal opcode.
    step(0, OP_J, 1, 0, 0, 0);
    step(0, OP_J, 1, 0, 1, 0);
    step(0, OP_J, 1, 0, 9, 0);
    step(0, OP_ADDI, 1, 0, 0, 0);
    step(0, OP_ADDI, 1, 0, 1, 0);
    step(0, OP_ADDI, 1, 0, 10, 0);
    step(0, OP_ADDI, 1, 0, 11, 0);
    step(0, OP_BAD, 1, 0, 0, 0);
    step(0, OP_BAD, 1, 0, 1, 1);

    // lw whose opcode input turns into sw during MEM_ADDR.
    step(0, OP_LW, 1, 0, 0, 0);
    step(0, OP_LW, 1, 0, 1, 0);
    step(0, OP_SW, 1, 0, 2, 0);
    step(0, OP_SW, 1, 0, 3, 0);
    step(0, OP_SW, 1, 0, 4, 0);

    // sw with one write wait.
    step(0, OP_SW, 1, 0, 0, 0);
    step(0, OP_SW, 1, 0, 1, 0);
    step(0, OP_SW, 1, 0, 2, 0);
    step(0, OP_SW, 0, 0, 5, 0);
    step(0, OP_SW, 1, 0, 5, 0);

    // lw reset while waiting in MEM_READ.
    step(0, OP_LW, 1, 0, 0, 0);
    step(0, OP_LW, 1, 0, 1, 0);
    step(0, OP_LW, 1, 0, 2, 0);
    step(0, OP_LW, 0, 0, 3, 0);
    step(1, OP_LW, 1, 0, 0, 0);
    step(0, OP_LW, 0, 0, 0, 0);
    step(0, OP_LW, 0, 0, 0, 0);

    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Main control FSM for the multi-cycle 32-bit MIPS datapath. It sequences instruction fetch, decode, execute, memory access and write-back by driving every datapath select and enable. It also forms the PC write enable from the branch condition and the ALU zero flag. It sits between the instruction register's opcode field and the shared PC/memory/register-file/ALU datapath, and waits on a single memory-ready handshake.

## Interface
- No parameters; opcodes are fixed: R-type 6'b000000, lw 6'b100011, sw 6'b101011, beq 6'b000100, j 6'b000010, addi 6'b001000.
- clk  input  1  rising-edge clock (one clock domain)
- reset  input  1  synchronous, active-high
- opcode  input  6  instr[31:26] from the instruction register; sampled only in DECODE
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes the current access this cycle
- pc_en  output  1  pc_write | (pc_write_cond & zero)
- pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a  output  1 each  datapath controls
- alu_src_b  output  2  00 = B register, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- alu_op  output  2  00 = add, 01 = subtract, 10 = decode funct
- pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- state  output  4  current state encoding, for debug
- illegal_op  output  1  high in DECODE when the opcode is unrecognised

## Operation
- States and encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, R_COMPLETE=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11. Encodings 12–15 are illegal and go to FETCH on the next edge.
- Every control output is 0 unless it is listed for the current state.
- FETCH
  - Outputs: mem_read=1, alu_src_b=01, alu_op=00, pc_source=00; ir_write=mem_ready; pc_write=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE
  - Outputs: alu_src_b=11, alu_op=00.
  - Next state by opcode: lw/sw → MEM_ADDR; R-type → EXECUTE; beq → BRANCH; j → JUMP; addi → ADDI_EXEC.
  - Any other opcode → FETCH, with illegal_op=1 for this cycle (instruction treated as a NOP).
- MEM_ADDR
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=00.
  - Next state: lw → MEM_READ; sw → MEM_WRITE. This uses the opcode latched in DECODE; a held internal copy is required, because the opcode input may change.
- MEM_READ
  - Outputs: mem_read=1, i_or_d=1.
  - Holds until mem_ready=1, then → MEM_WB.
- MEM_WB
  - Outputs: reg_write=1, mem_to_reg=1, reg_dst=0.
  - → FETCH.
- MEM_WRITE
  - Outputs: mem_write=1, i_or_d=1, held throughout any wait.
  - Holds until mem_ready=1, then → FETCH.
- EXECUTE
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=10.
  - → R_COMPLETE.
- R_COMPLETE
  - Outputs: reg_dst=1, reg_write=1, mem_to_reg=0.
  - → FETCH.
- BRANCH
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01.
  - → FETCH.
- JUMP
  - Outputs: pc_write=1, pc_source=10.
  - → FETCH.
- ADDI_EXEC
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=00.
  - → ADDI_WB.
- ADDI_WB
  - Outputs: reg_write=1, reg_dst=0, mem_to_reg=0.
  - → FETCH.
- pc_en is combinational from the current state and zero. Outside BRANCH, zero has no effect.
- mem_read and mem_write are never high in the same cycle.

## Timing
- Reset
  - While reset=1, every output, pc_en and illegal_op included, is forced to 0, and state reads 0.
  - On each rising edge with reset=1, the state register loads FETCH.
  - The first cycle after reset deasserts is FETCH.
- Reset mid-instruction: any state returns to FETCH on the next edge, and no write enable is asserted during the reset cycle.
- Cycle counts with mem_ready held at 1: lw 5; sw 4; R-type 4; addi 4; beq 3; j 3; illegal opcode 2.
- Each cycle of mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle. Control outputs stay stable across these wait cycles, except ir_write/pc_write, which track mem_ready.
- All state transitions happen on the rising edge of clk. Outputs settle combinationally within the same cycle.

## Test plan
- Reset and stall
  - Stimulus: hold reset=1 for 2 cycles with mem_ready=1; release.
  - Required: all outputs 0 while reset=1; state=0 after release. While mem_ready=0, FETCH holds with ir_write=0 and pc_en=0. In the first cycle with mem_ready=1, ir_write=1 and pc_en=1.
- lw with memory waits
  - Stimulus: opcode=6'b100011; mem_ready=0 for 2 cycles in MEM_READ.
  - Required: state sequence 0,1,2,3,3,3,4,0; in state 4, reg_write=1, mem_to_reg=1, reg_dst=0.
- sw and R-type
  - Stimulus: opcode=6'b101011, then opcode=6'b000000.
  - Required: sw gives 0,1,2,5,0 with mem_write=1 and i_or_d=1 in state 5. R-type gives 0,1,6,7,0 with alu_op=10 in state 6 and reg_dst=1, reg_write=1 in state 7.
- beq, both zero values
  - Stimulus: opcode=6'b000100, once with zero=1 and once with zero=0.
  - Required: in state 8, pc_en=1 when zero=1 and pc_en=0 when zero=0; alu_op=01 and pc_source=01 in both runs.
- j, addi and illegal opcode
  - Stimulus: opcode=6'b000010, then 6'b001000, then 6'b111111.
  - Required: j gives 0,1,9,0 with pc_source=10 and pc_en=1 in state 9. addi gives 0,1,10,11,0. The illegal opcode gives 0,1,0 with illegal_op=1 in state 1 only.
- Opcode change and mid-instruction reset
  - Stimulus: run lw, change opcode to 6'b101011 while in MEM_ADDR; in a later run, assert reset in MEM_READ.
  - Required: the first run still goes to MEM_READ (the latched opcode is used). The reset run reaches FETCH on the next edge, with no reg_write or mem_write in between.
